floo_offload_reduction_sched: RTL and testbench

FLOO_OFFLOAD_REDUCTION_SCHED -- requirements
Module: floo_offload_reduction_sched

---
 rtl/floo_offload_reduction_sched.sv | 189 ++++++++++++++++++
 tb/tb_floo_offload_reduction_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floo_offload_reduction_sched.sv
`default_nettype none
// ============================================================================
//  Module      : floo_offload_reduction_sched
//  Description : Collects tagged reduction operands that arrive over several
//                routes. Each tag owns one table entry. The module offers
//                completed reductions to a single shared offload unit in
//                strict tag order, and retires them when the unit reports
//                that it is done.
//  Revision    : 1.0 - initial release
// ============================================================================
module floo_offload_reduction_sched #(
  parameter int unsigned NumRoutes = 1,
  parameter int unsigned RdTagBits = 1,
  parameter type         TAG_T     = logic [RdTagBits-1:0]
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic [NumRoutes-1:0]                in_valid_i,
  input  TAG_T [NumRoutes-1:0]                in_tag_i,
  input  logic [NumRoutes-1:0][NumRoutes-1:0] in_mask_i,
  output logic [NumRoutes-1:0]                in_ready_o,
  output logic                                issue_valid_o,
  output TAG_T                                issue_tag_o,
  output logic [NumRoutes-1:0]                issue_mask_o,
  input  logic                                issue_ready_i,
  input  logic                                done_valid_i,
  input  TAG_T                                done_tag_i,
  output logic                                busy_o,
  output logic                                err_o
);

  localparam int unsigned NumTags = 2 ** RdTagBits;

  typedef logic [RdTagBits-1:0] idx_t;
  typedef logic [NumRoutes-1:0] route_vec_t;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StReady   = 2'd2,
    StBusy    = 2'd3
  } state_e;

  // Per-entry table, issue head pointer and sticky error flag
  state_e     state_q   [NumTags];
  state_e     state_d   [NumTags];
  route_vec_t mask_q    [NumTags];
  route_vec_t mask_d    [NumTags];
  route_vec_t arrived_q [NumTags];
  route_vec_t arrived_d [NumTags];
  idx_t       head_q;
  idx_t       head_d;
  logic       err_q;
  logic       err_d;

  // Scratch used while merging the accepts of one cycle
  logic       captured  [NumTags];
  idx_t       idx_v;
  idx_t       done_idx_v;
  route_vec_t own_v;

  route_vec_t accept;

  // A route may deliver only into a collecting (or idle) entry, and only once
  // per use of the tag. This also stalls early elements of the next
  // wrap-around use while the previous use is still READY or BUSY.
  always_comb begin
    in_ready_o = '0;
    for (int unsigned r = 0; r < NumRoutes; r++) begin
      in_ready_o[r] = ((state_q[idx_t'(in_tag_i[r])] == StIdle) ||
                       (state_q[idx_t'(in_tag_i[r])] == StCollect)) &&
                      !arrived_q[idx_t'(in_tag_i[r])][r];
    end
  end

  assign accept = in_valid_i & in_ready_o;

  // The head entry alone is offered, which keeps the issue order equal to the tag order
  assign issue_valid_o = (state_q[head_q] == StReady);
  assign issue_tag_o   = TAG_T'(head_q);
  assign issue_mask_o  = mask_q[head_q];
  assign err_o         = err_q;

  // Report activity when any entry is outside IDLE
  always_comb begin
    busy_o = 1'b0;
    for (int unsigned e = 0; e < NumTags; e++) begin
      busy_o = busy_o | (state_q[e] != StIdle);
    end
  end

  // Next-state computation. Accepts, issue and done all touch disjoint
  // entry states (IDLE/COLLECT, READY, BUSY), so each can be applied
  // independently within the same cycle.
  always_comb begin
    for (int unsigned e = 0; e < NumTags; e++) begin
      state_d[e]   = state_q[e];
      mask_d[e]    = mask_q[e];
      arrived_d[e] = arrived_q[e];
      captured[e]  = (state_q[e] != StIdle);
    end
    head_d     = head_q;
    err_d      = err_q;
    idx_v      = '0;
    done_idx_v = '0;
    own_v      = '0;

    // Merge accepts in route order, so the lowest-index route into an idle
    // entry supplies the mask that later contributors are checked against
    for (int unsigned r = 0; r < NumRoutes; r++) begin
      if (accept[r]) begin
        idx_v    = idx_t'(in_tag_i[r]);
        own_v    = '0;
        own_v[r] = 1'b1;
        if ((in_mask_i[r] == '0) || ((in_mask_i[r] & own_v) == '0)) begin
          err_d = 1'b1;
        end
        if (!captured[idx_v]) begin
          mask_d[idx_v]   = in_mask_i[r] | own_v;
          captured[idx_v] = 1'b1;
          state_d[idx_v]  = StCollect;
        end else begin
          if (in_mask_i[r] != mask_d[idx_v]) begin
            err_d = 1'b1;
          end
          mask_d[idx_v] = mask_d[idx_v] | own_v;
        end
        arrived_d[idx_v] = arrived_d[idx_v] | own_v;
      end
    end

    // Completion is judged on the updated vectors so the entry is READY
    // right after the edge that latches the last operand
    for (int unsigned e = 0; e < NumTags; e++) begin
      if ((state_d[e] == StCollect) && (arrived_d[e] == mask_d[e])) begin
        state_d[e] = StReady;
      end
    end

    if (issue_valid_o && issue_ready_i) begin
      state_d[head_q] = StBusy;
      head_d          = head_q + idx_t'(1);
    end

    // Done carries no back-pressure; a stray done is dropped and flagged
    if (done_valid_i) begin
      done_idx_v = idx_t'(done_tag_i);
      if (state_q[done_idx_v] == StBusy) begin
        state_d[done_idx_v]   = StIdle;
        mask_d[done_idx_v]    = '0;
        arrived_d[done_idx_v] = '0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers; flush wipes the table regardless of same-cycle events
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned e = 0; e < NumTags; e++) begin
        state_q[e]   <= StIdle;
        mask_q[e]    <= '0;
        arrived_q[e] <= '0;
      end
      head_q <= '0;
      err_q  <= 1'b0;
    end else if (flush_i) begin
      for (int unsigned e = 0; e < NumTags; e++) begin
        state_q[e]   <= StIdle;
        mask_q[e]    <= '0;
        arrived_q[e] <= '0;
      end
      head_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int unsigned e = 0; e < NumTags; e++) begin
        state_q[e]   <= state_d[e];
        mask_q[e]    <= mask_d[e];
        arrived_q[e] <= arrived_d[e];
      end
      head_q <= head_d;
      err_q  <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_floo_offload_reduction_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_floo_offload_reduction_sched
//  Description : Directed self-checking bench, three routes and four tags.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_floo_offload_reduction_sched;

  logic            clk;
  logic            rst_ni;
  logic            flush;
  logic [2:0]      in_valid;
  logic [2:0][1:0] in_tag;
  logic [2:0][2:0] in_mask;
  logic [2:0]      in_ready;
  logic            issue_valid;
  logic [1:0]      issue_tag;
  logic [2:0]      issue_mask;
  logic            issue_ready;
  logic            done_valid;
  logic [1:0]      done_tag;
  logic            busy;
  logic            err;

  int n_cmp;
  int n_err;

  floo_offload_reduction_sched #(
    .NumRoutes (3),
    .RdTagBits (2),
    .TAG_T     (logic [1:0])
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .flush_i       (flush),
    .in_valid_i    (in_valid),
    .in_tag_i      (in_tag),
    .in_mask_i     (in_mask),
    .in_ready_o    (in_ready),
    .issue_valid_o (issue_valid),
    .issue_tag_o   (issue_tag),
    .issue_mask_o  (issue_mask),
    .issue_ready_i (issue_ready),
    .done_valid_i  (done_valid),
    .done_tag_i    (done_tag),
    .busy_o        (busy),
    .err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_issue(input string tag, input int v, input int t, input int m);
    check({tag, ".valid"}, 32'(issue_valid), 32'(v));
    check({tag, ".tag"},   32'(issue_tag),   32'(t));
    check({tag, ".mask"},  32'(issue_mask),  32'(m));
  endtask

  task automatic clr_in();
    flush       = 1'b0;
    in_valid    = '0;
    in_tag      = '0;
    in_mask     = '0;
    issue_ready = 1'b0;
    done_valid  = 1'b0;
    done_tag    = '0;
  endtask

  task automatic send(input int r, input int t, input logic [2:0] m);
    in_valid[r] = 1'b1;
    in_tag[r]   = 2'(t);
    in_mask[r]  = m;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst_ni = 1'b0;
    clr_in();
    #3;
    // ---- reset state ----
    chk_issue("rst", 0, 0, 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.err", 32'(err), 0);
    check("rst.ready", 32'(in_ready), 32'h7);
    tick();
    rst_ni = 1'b1;
    tick();

    // ---- basic reduction: routes 0,1 tag 0 ----
    clr_in();
    send(0, 0, 3'b011);
    send(1, 0, 3'b011);
    #1;
    check("s1.ready", 32'(in_ready), 32'h7);
    check("s1.nvalid", 32'(issue_valid), 0);
    tick();
    clr_in();
    chk_issue("s1.issue", 1, 0, 3);
    check("s1.busy", 32'(busy), 1);
    issue_ready = 1'b1;
    tick();
    clr_in();
    #1;
    check("s1.after_issue", 32'(issue_valid), 0);
    check("s1.busy_entry_ready", 32'(in_ready), 0);
    done_valid = 1'b1;
    done_tag   = 2'd0;
    tick();
    clr_in();
    #1;
    check("s1.idle_busy", 32'(busy), 0);
    check("s1.err", 32'(err), 0);
    check("s1.ready_back", 32'(in_ready), 32'h7);
    flush = 1'b1;
    tick();

    // ---- in-order issue: tag 1 completes before tag 0 ----
    clr_in();
    send(0, 1, 3'b101);
    send(1, 0, 3'b011);
    tick();
    clr_in();
    send(2, 1, 3'b101);
    tick();
    clr_in();
    check("s2.no_overtake", 32'(issue_valid), 0);
    send(0, 0, 3'b011);
    tick();
    clr_in();
    chk_issue("s2.head0", 1, 0, 3);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_issue("s2.stall", 1, 0, 3);
    end
    issue_ready = 1'b1;
    tick();
    chk_issue("s2.tag1_next", 1, 1, 5);
    tick();
    clr_in();
    check("s2.drained", 32'(issue_valid), 0);
    done_valid = 1'b1;
    done_tag   = 2'd0;
    tick();
    done_tag   = 2'd1;
    tick();
    clr_in();
    check("s2.busy", 32'(busy), 0);
    check("s2.err", 32'(err), 0);

    // ---- duplicate element on route 0, head is now 2 ----
    clr_in();
    send(0, 2, 3'b011);
    #1;
    check("s3.first_ready", 32'(in_ready[0]), 1);
    tick();
    clr_in();
    send(0, 2, 3'b011);
    #1;
    check("s3.dup_hold", 32'(in_ready[0]), 0);
    tick();
    clr_in();
    send(0, 2, 3'b011);
    send(1, 2, 3'b011);
    #1;
    check("s3.ready_vec", 32'(in_ready), 32'h6);
    tick();
    clr_in();
    send(0, 2, 3'b011);
    #1;
    chk_issue("s3.issue", 1, 2, 3);
    check("s3.hold_ready", 32'(in_ready[0]), 0);
    issue_ready = 1'b1;
    tick();
    clr_in();
    send(0, 2, 3'b011);
    done_valid = 1'b1;
    done_tag   = 2'd2;
    #1;
    check("s3.done_cycle_hold", 32'(in_ready[0]), 0);
    tick();
    clr_in();
    send(0, 2, 3'b011);
    #1;
    check("s3.after_done_ready", 32'(in_ready[0]), 1);
    check("s3.after_done_busy", 32'(busy), 0);
    tick();
    clr_in();
    #1;
    check("s3.collect_busy", 32'(busy), 1);
    check("s3.err", 32'(err), 0);
    flush = 1'b1;
    tick();
    clr_in();
    check("s3.flush_busy", 32'(busy), 0);

    // ---- protocol errors ----
    send(0, 0, 3'b010);
    tick();
    clr_in();
    check("s4.bad_mask_err", 32'(err), 1);
    tick();
    check("s4.err_sticky", 32'(err), 1);
    flush = 1'b1;
    tick();
    clr_in();
    check("s4.flush_err", 32'(err), 0);
    check("s4.flush_busy", 32'(busy), 0);
    done_valid = 1'b1;
    done_tag   = 2'd3;
    tick();
    clr_in();
    check("s4.stray_done_err", 32'(err), 1);
    check("s4.stray_done_busy", 32'(busy), 0);
    flush = 1'b1;
    tick();
    clr_in();
    check("s4.flush_err2", 32'(err), 0);

    // ---- cycle all tags twice, head wraps 3 -> 0 ----
    for (int k = 0; k < 8; k++) begin
      clr_in();
      send(0, k % 4, 3'b111);
      send(1, k % 4, 3'b111);
      send(2, k % 4, 3'b111);
      tick();
      clr_in();
      chk_issue($sformatf("s5.wrap%0d", k), 1, k % 4, 7);
      issue_ready = 1'b1;
      tick();
      clr_in();
      done_valid = 1'b1;
      done_tag   = 2'(k % 4);
      tick();
      clr_in();
      check($sformatf("s5.idle%0d", k), 32'(busy), 0);
    end
    check("s5.err", 32'(err), 0);

    // ---- reset mid-operation: one BUSY, three READY ----
    clr_in();
    send(0, 0, 3'b111);
    send(1, 0, 3'b111);
    send(2, 0, 3'b111);
    tick();
    clr_in();
    issue_ready = 1'b1;
    tick();
    clr_in();
    send(0, 1, 3'b001);
    send(1, 2, 3'b010);
    send(2, 3, 3'b100);
    tick();
    clr_in();
    chk_issue("s6.pre_rst", 1, 1, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_issue("s6.in_rst", 0, 0, 0);
    check("s6.rst_busy", 32'(busy), 0);
    check("s6.rst_err", 32'(err), 0);
    check("s6.rst_ready", 32'(in_ready), 32'h7);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    tick();
    chk_issue("s6.post_rst", 0, 0, 0);
    check("s6.post_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
